// File: rtl/inst_widener.sv
`default_nettype none
// ============================================================================
//  Module      : inst_widener
//  Description : Bridges a 32-bit core instruction-fetch port onto a wide
//                instruction-memory port (WIDE_DATA_WIDTH bits). A single
//                line buffer serves sequential fetches inside one line
//                without issuing a new wide request.
//
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    flush                    one-cycle pulse, invalidates the line (fence.i)
//    core_i_narrow_*          core side, req/gnt/rvalid slave, 32-bit data
//    core_i_wide_*            memory side, req/gnt/rvalid master, wide data
//
//  Optional build macro
//    INST_WIDENER_STATS_EN    adds stats_clr input and saturating
//                             hit_cnt / miss_cnt outputs
//
//  Revision    : 1.0  initial release
// ============================================================================
module inst_widener #(
    parameter int WIDE_DATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       core_i_narrow_req,
    input  logic [31:0]                core_i_narrow_addr,
    output logic                       core_i_narrow_gnt,
    output logic                       core_i_narrow_rvalid,
    output logic [31:0]                core_i_narrow_rdata,
    output logic                       core_i_wide_req,
    output logic [31:0]                core_i_wide_addr,
    input  logic                       core_i_wide_gnt,
    input  logic                       core_i_wide_rvalid,
    input  logic [WIDE_DATA_WIDTH-1:0] core_i_wide_rdata
`ifdef INST_WIDENER_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [31:0]                hit_cnt,
    output logic [31:0]                miss_cnt
`endif
);

    localparam int WORDS = WIDE_DATA_WIDTH / 32;
    localparam int OFFS  = $clog2(WIDE_DATA_WIDTH / 8);
    localparam int IDXW  = OFFS - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WREQ  = 2'd1,
        ST_WWAIT = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_line_valid;
    logic [31:OFFS]             r_line_tag;
    logic [WIDE_DATA_WIDTH-1:0] r_line_data;
    logic [31:OFFS]             r_miss_addr;
    logic                       r_flush_pend;
    logic                       r_wide_req;
    logic                       r_rvalid;
    logic [31:0]                r_rdata;

    logic [31:OFFS]             w_tag;
    logic [IDXW-1:0]            w_idx;
    logic                       w_hit;
    logic                       w_gnt;
    logic                       w_miss;
    logic                       w_refill_done;
    logic [31:0]                w_words [WORDS];
    logic                       w_unused;

    // Word-select view of the line buffer.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign w_words[gi] = r_line_data[32*gi +: 32];
        end
    endgenerate

    assign w_tag    = core_i_narrow_addr[31:OFFS];
    assign w_idx    = core_i_narrow_addr[OFFS-1:2];
    assign w_unused = ^core_i_narrow_addr[1:0];

    // A same-cycle flush suppresses the hit so the request becomes a miss.
    assign w_hit  = (r_state == ST_IDLE) && r_line_valid &&
                    (w_tag == r_line_tag) && !flush;
    assign w_gnt  = core_i_narrow_req && w_hit;
    assign w_miss = (r_state == ST_IDLE) && core_i_narrow_req && !w_hit;
    assign w_refill_done = (r_state == ST_WWAIT) && core_i_wide_rvalid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_miss)              w_state_nxt = ST_WREQ;
            ST_WREQ:  if (core_i_wide_gnt)     w_state_nxt = ST_WWAIT;
            ST_WWAIT: if (core_i_wide_rvalid)  w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_line_valid <= 1'b0;
            r_line_tag   <= '0;
            r_line_data  <= '0;
            r_miss_addr  <= '0;
            r_flush_pend <= 1'b0;
            r_wide_req   <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_rdata <= w_words[w_idx];
            end

            if ((r_state == ST_IDLE) && flush) begin
                r_line_valid <= 1'b0;
            end

            if (w_miss) begin
                r_miss_addr <= w_tag;
                r_wide_req  <= 1'b1;
            end

            if ((r_state == ST_WREQ) && core_i_wide_gnt) begin
                r_wide_req <= 1'b0;
            end

            // A flush seen while a refill is in flight must not let the
            // incoming (possibly stale) line become valid.
            if ((r_state != ST_IDLE) && flush) begin
                r_flush_pend <= 1'b1;
            end

            if (w_refill_done) begin
                r_line_data  <= core_i_wide_rdata;
                r_line_tag   <= r_miss_addr;
                r_line_valid <= !(r_flush_pend || flush);
                r_flush_pend <= 1'b0;
            end
        end
    end

    assign core_i_narrow_gnt    = w_gnt;
    assign core_i_narrow_rvalid = r_rvalid;
    assign core_i_narrow_rdata  = r_rdata;
    assign core_i_wide_req      = r_wide_req;
    assign core_i_wide_addr     = {r_miss_addr, {OFFS{1'b0}}};

`ifdef INST_WIDENER_STATS_EN
    logic        r_refill_done;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // The gnt right after a refill serves the request that missed; it is
    // already accounted for as a miss and is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refill_done <= 1'b0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
        end else begin
            r_refill_done <= w_refill_done;
            if (stats_clr) begin
                r_hit_cnt  <= '0;
                r_miss_cnt <= '0;
            end else begin
                if (w_gnt && !r_refill_done && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
                if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_widener.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_widener
//  Description : Directed self-checking bench for inst_widener (128-bit line).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_widener;

    localparam int W = 128;

    localparam logic [W-1:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [W-1:0] LINE_B = 128'h44444444_33333333_22222222_11111111;
    localparam logic [W-1:0] LINE_C = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
    localparam logic [W-1:0] LINE_D = 128'h9A9A9A9A_7B7B7B7B_6C6C6C6C_5A5A5A5A;
    localparam logic [W-1:0] LINE_S = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          req;
    logic [31:0]   addr;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          wide_req;
    logic [31:0]   wide_addr;
    logic          wide_gnt;
    logic          wide_rvalid;
    logic [W-1:0]  wide_rdata;
`ifdef INST_WIDENER_STATS_EN
    logic          stats_clr;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    inst_widener #(.WIDE_DATA_WIDTH(W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .core_i_narrow_req    (req),
        .core_i_narrow_addr   (addr),
        .core_i_narrow_gnt    (gnt),
        .core_i_narrow_rvalid (rvalid),
        .core_i_narrow_rdata  (rdata),
        .core_i_wide_req      (wide_req),
        .core_i_wide_addr     (wide_addr),
        .core_i_wide_gnt      (wide_gnt),
        .core_i_wide_rvalid   (wide_rvalid),
        .core_i_wide_rdata    (wide_rdata)
`ifdef INST_WIDENER_STATS_EN
        ,
        .stats_clr            (stats_clr),
        .hit_cnt              (hit_cnt),
        .miss_cnt             (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Present a request that must miss; returns at the negedge of the
    // first WREQ cycle.
    task automatic start_miss(input logic [31:0] a, input logic fl);
        @(negedge clk);
        req   = 1'b1;
        addr  = a;
        flush = fl;
        #1;
        check("miss_no_gnt", gnt, 1'b0);
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Serve one wide transaction: gnt after gw stall cycles, one empty WWAIT
    // cycle (optionally with flush), then the line. Returns in first IDLE cycle.
    task automatic wide_phase(input logic [31:0] wa, input int gw,
                              input logic fl_wait, input logic [W-1:0] line);
        #1;
        check("wreq", wide_req, 1'b1);
        check("waddr", wide_addr, wa);
        check("wreq_no_gnt", gnt, 1'b0);
        for (int i = 0; i < gw; i++) begin
            @(negedge clk);
            #1;
            check("bp_wreq", wide_req, 1'b1);
            check("bp_waddr", wide_addr, wa);
            check("bp_no_gnt", gnt, 1'b0);
        end
        wide_gnt = 1'b1;
        @(negedge clk);
        wide_gnt = 1'b0;
        flush    = fl_wait;
        #1;
        check("wreq_dropped", wide_req, 1'b0);
        check("wwait_no_gnt", gnt, 1'b0);
        @(negedge clk);
        flush       = 1'b0;
        wide_rvalid = 1'b1;
        wide_rdata  = line;
        #1;
        check("wwait_no_gnt2", gnt, 1'b0);
        @(negedge clk);
        wide_rvalid = 1'b0;
    endtask

    // The held request must now hit; its response arrives one cycle later.
    task automatic finish_hit(input logic [31:0] exp);
        #1;
        check("refill_gnt", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0;
        #1;
        check("refill_rvalid", rvalid, 1'b1);
        check("refill_rdata", rdata, exp);
    endtask

    logic [31:0] hit_addr [3];
    logic [31:0] hit_exp  [3];

    initial begin
        rst = 1'b1; flush = 1'b0; req = 1'b0; addr = '0;
        wide_gnt = 1'b0; wide_rvalid = 1'b0; wide_rdata = '0;
`ifdef INST_WIDENER_STATS_EN
        stats_clr = 1'b0;
`endif
        hit_addr[0] = 32'h104; hit_addr[1] = 32'h108; hit_addr[2] = 32'h10C;
        hit_exp[0]  = 32'hBBBBBBBB; hit_exp[1] = 32'hCCCCCCCC; hit_exp[2] = 32'hDDDDDDDD;

        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wreq", wide_req, 1'b0);
        check("rst_waddr", wide_addr, 32'h0);
        rst = 1'b0;

        // Fill line 0x100, then three back-to-back hits.
        start_miss(32'h100, 1'b0);
        wide_phase(32'h100, 0, 1'b0, LINE_A);
        finish_hit(32'hAAAAAAAA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req  = 1'b1;
            addr = hit_addr[i];
            #1;
            check("hit_gnt", gnt, 1'b1);
            check("hit_no_wreq", wide_req, 1'b0);
            if (i > 0) begin
                check("hit_rvalid", rvalid, 1'b1);
                check("hit_rdata", rdata, hit_exp[i-1]);
            end
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        check("hit_rvalid_last", rvalid, 1'b1);
        check("hit_rdata_last", rdata, hit_exp[2]);
        @(negedge clk);
        #1;
        check("rvalid_pulse", rvalid, 1'b0);
        check("rdata_hold", rdata, 32'hDDDDDDDD);
        check("idle_no_wreq", wide_req, 1'b0);

`ifdef INST_WIDENER_STATS_EN
        check("hit_cnt", hit_cnt, 32'd3);
        check("miss_cnt", miss_cnt, 32'd1);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        check("hit_cnt_clr", hit_cnt, 32'd0);
        check("miss_cnt_clr", miss_cnt, 32'd0);
`endif

        // Line crossing.
        start_miss(32'h110, 1'b0);
        wide_phase(32'h110, 0, 1'b0, LINE_B);
        finish_hit(32'h11111111);

        // Unaligned address with wide backpressure of 5 cycles.
        start_miss(32'h106, 1'b0);
        wide_phase(32'h100, 5, 1'b0, LINE_A);
        finish_hit(32'hBBBBBBBB);

        // Flush in IDLE with a same-cycle request to a resident line.
        start_miss(32'h104, 1'b1);
        wide_phase(32'h100, 0, 1'b0, LINE_A);
        finish_hit(32'hBBBBBBBB);

        // Flush during WWAIT: line stays invalid, second wide request.
        start_miss(32'h300, 1'b0);
        wide_phase(32'h300, 0, 1'b1, LINE_C);
        #1;
        check("flushed_no_gnt", gnt, 1'b0);
        check("flushed_no_rvalid", rvalid, 1'b0);
        @(negedge clk);
        wide_phase(32'h300, 0, 1'b0, LINE_C);
        finish_hit(32'h0C0C0C0C);

        // Reset while waiting for the line, then a stray response.
        start_miss(32'h200, 1'b0);
        #1;
        check("rr_wreq", wide_req, 1'b1);
        wide_gnt = 1'b1;
        @(negedge clk);
        wide_gnt = 1'b0;
        req      = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        wide_rvalid = 1'b1;
        wide_rdata  = LINE_S;
        #1;
        check("rr_wreq_cleared", wide_req, 1'b0);
        @(negedge clk);
        wide_rvalid = 1'b0;
        #1;
        check("stray_no_rvalid", rvalid, 1'b0);
        start_miss(32'h000, 1'b0);
        wide_phase(32'h000, 0, 1'b0, LINE_D);
        finish_hit(32'h5A5A5A5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
